// File: rtl/neuron_mac_datapath.sv
// MAC datapath: reads neuron/weight memories for each incoming term, multiplies, accumulates,
// and writes the shifted/ReLU'd/saturated sum back to neuron memory at each neuron boundary.
module neuron_mac_datapath #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int ACC_W   = 40,
    parameter int NADDR_W = 12,
    parameter int WADDR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NADDR_W-1:0] input_neuron_addr,
    input  logic [WADDR_W-1:0] input_weight_addr,
    input  logic [NADDR_W-1:0] output_neuron_addr,
    input  logic               reset_mult_acc,
    input  logic               write_neuron,
    input  logic               done,
    output logic [NADDR_W-1:0] neuron_rd_addr,
    input  logic [DATA_W-1:0]  neuron_rd_data,
    output logic [WADDR_W-1:0] weight_rd_addr,
    input  logic [DATA_W-1:0]  weight_rd_data,
    output logic               neuron_wr_en,
    output logic [NADDR_W-1:0] neuron_wr_addr,
    output logic [DATA_W-1:0]  neuron_wr_data,
    output logic               acc_overflow,
    output logic               mlp_done
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int DEPTH  = 3;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};

    // Per-term control that rides alongside the memory/multiply pipeline
    typedef struct packed {
        logic               valid;
        logic               flush;
        logic               wr;
        logic               clr;
        logic [NADDR_W-1:0] waddr;
    } meta_t;

    logic                       done_seen_q, done_seen_d;
    logic [NADDR_W-1:0]         prev_out_q, prev_out_d;
    logic [NADDR_W-1:0]         nrd_addr_q, nrd_addr_d;
    logic [WADDR_W-1:0]         wrd_addr_q, wrd_addr_d;
    meta_t                      meta_q [DEPTH];
    meta_t                      meta_d [DEPTH];
    logic signed [PROD_W-1:0]   prod_q, prod_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       wr_en_q, wr_en_d;
    logic [NADDR_W-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]          wr_data_q, wr_data_d;
    logic                       ovf_q, ovf_d;
    logic                       fin_q, fin_d;
    logic                       mlp_done_q, mlp_done_d;

    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W:0]      sum_wide;
    logic                       sum_ovf;

    assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    assign sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
    assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    function automatic logic [DATA_W-1:0] act(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] s;
        s = x >>> FRAC_W;
        if (s[ACC_W-1])
            return '0;
        else if (s > ACT_MAX)
            return ACT_MAX[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
    endfunction

    always_comb begin
        done_seen_d = done_seen_q;
        prev_out_d  = prev_out_q;
        nrd_addr_d  = nrd_addr_q;
        wrd_addr_d  = wrd_addr_q;
        meta_d[0]   = '0;
        for (int i = 1; i < DEPTH; i++)
            meta_d[i] = meta_q[i-1];
        prod_d      = PROD_W'($signed(neuron_rd_data)) * PROD_W'($signed(weight_rd_data));
        acc_d       = acc_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        ovf_d       = ovf_q;
        fin_d       = 1'b0;
        mlp_done_d  = mlp_done_q | fin_q;

        // The done edge becomes a flush term that only commits the open neuron
        if (!done_seen_q) begin
            meta_d[0].valid = 1'b1;
            meta_d[0].waddr = prev_out_q;
            if (done) begin
                done_seen_d     = 1'b1;
                meta_d[0].flush = 1'b1;
                meta_d[0].wr    = 1'b1;
            end else begin
                meta_d[0].wr    = write_neuron;
                meta_d[0].clr   = reset_mult_acc;
                prev_out_d      = output_neuron_addr;
                nrd_addr_d      = input_neuron_addr;
                wrd_addr_d      = input_weight_addr;
            end
        end

        if (meta_q[DEPTH-1].valid) begin
            if (meta_q[DEPTH-1].wr) begin
                wr_en_d   = 1'b1;
                wr_addr_d = meta_q[DEPTH-1].waddr;
                wr_data_d = act(acc_q);
            end
            if (meta_q[DEPTH-1].flush) begin
                acc_d = '0;
                fin_d = 1'b1;
            end else if (meta_q[DEPTH-1].clr) begin
                acc_d = prod_ext;
            end else if (sum_ovf) begin
                acc_d = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_wide[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_seen_q <= 1'b0;
            prev_out_q  <= '0;
            nrd_addr_q  <= '0;
            wrd_addr_q  <= '0;
            for (int i = 0; i < DEPTH; i++)
                meta_q[i] <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ovf_q       <= 1'b0;
            fin_q       <= 1'b0;
            mlp_done_q  <= 1'b0;
        end else begin
            done_seen_q <= done_seen_d;
            prev_out_q  <= prev_out_d;
            nrd_addr_q  <= nrd_addr_d;
            wrd_addr_q  <= wrd_addr_d;
            for (int i = 0; i < DEPTH; i++)
                meta_q[i] <= meta_d[i];
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ovf_q       <= ovf_d;
            fin_q       <= fin_d;
            mlp_done_q  <= mlp_done_d;
        end
    end

    assign neuron_rd_addr = nrd_addr_q;
    assign weight_rd_addr = wrd_addr_q;
    assign neuron_wr_en   = wr_en_q;
    assign neuron_wr_addr = wr_addr_q;
    assign neuron_wr_data = wr_data_q;
    assign acc_overflow   = ovf_q;
    assign mlp_done       = mlp_done_q;

endmodule
